// File: rtl/bcd_xs3_if.sv
// Shared constants for the bcd_xs3_seq block; the handshake interface itself is in bcd_xs3_seq_if.sv.
// Latency: n/a (no logic).
// Backpressure: n/a (no logic).
package bcd_xs3_pkg;
  localparam int XS3_BIAS = 3;
endpackage

// File: rtl/bcd_xs3_seq_if.sv
// Handshake bundle between BCD producer, the bcd_xs3_seq sequencer and the Excess-3 consumer.
// Latency: none, wires only.
// Backpressure: in_ready/out_ready carry the valid/ready flow control in each direction.
interface bcd_xs3_seq_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_xs3;
  logic                  out_err;
  logic                  busy;

  // Producer/consumer side: drives the word in and the acceptance of the result.
  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_xs3, out_err, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_xs3, out_err, busy
  );
endinterface

// File: rtl/bcd_xs3_seq.sv
// Converts a packed DIGITS-wide BCD word to Excess-3, one digit per cycle through one 4-bit slice.
// Latency: accept at edge k, out_valid after edge k+DIGITS; next accept no earlier than k+DIGITS+2.
// Backpressure: result held in DONE while out_ready=0; in_ready low outside IDLE. Macro BCD_XS3_ERR_CHECK_EN flags digits > 9.
module bcd_xs3_seq #(
  parameter int DIGITS = 4
) (
  input  logic         clk,
  input  logic         rst,
  bcd_xs3_seq_if.slave bus
);

  localparam int                W        = 4 * DIGITS;
  localparam int                IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [W-1:0]      word_q, word_d;
  logic [W-1:0]      result_q, result_d;
  logic [3:0]        digit;
  logic [3:0]        nib;
  logic              in_ready_c;
  logic              out_valid_c;
  logic              busy_c;

`ifdef BCD_XS3_ERR_CHECK_EN
  logic              err_q, err_d;
  logic              digit_bad;
`endif

  // Shared digit slice: picks the current digit and produces its Excess-3 code.
  always_comb begin
    digit = word_q[4*idx_q +: 4];
    nib   = digit + 4'd3;
`ifdef BCD_XS3_ERR_CHECK_EN
    digit_bad = (digit > 4'd9);
    if (digit_bad) begin
      nib = 4'hF;
    end
`endif
  end

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    result_d    = result_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
`ifdef BCD_XS3_ERR_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          word_d   = bus.in_bcd;
          result_d = '0;
          idx_d    = '0;
`ifdef BCD_XS3_ERR_CHECK_EN
          err_d    = 1'b0;
`endif
          state_d  = S_CONV;
        end
      end
      S_CONV: begin
        busy_c                = 1'b1;
        result_d[4*idx_q +: 4] = nib;
`ifdef BCD_XS3_ERR_CHECK_EN
        err_d                 = err_q | digit_bad;
`endif
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Word, digit index and assembled result; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      word_q   <= '0;
      result_q <= '0;
    end else begin
      idx_q    <= idx_d;
      word_q   <= word_d;
      result_q <= result_d;
    end
  end

`ifdef BCD_XS3_ERR_CHECK_EN
  // Sticky per-word flag for any digit above 9.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.out_err = err_q;
`else
  assign bus.out_err = 1'b0;
`endif

  // Never advertise readiness while reset is being applied.
  assign bus.in_ready  = in_ready_c & ~rst;
  assign bus.out_valid = out_valid_c;
  assign bus.out_xs3   = result_q;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Self-checking bench for bcd_xs3_seq (DIGITS = 4) against a digit-arithmetic reference model.
// Latency: checks accept-to-out_valid distance and accept-to-accept interval.
// Backpressure: stalls out_ready and checks the result is held and in_valid ignored.
module tb_bcd_xs3_seq;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  bcd_xs3_seq_if #(.DIGITS(DIGITS)) bus ();

  bcd_xs3_seq #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each digit d maps to d+3 mod 16, or to F with the flag raised when checking is on.
  function automatic void ref_xs3(input logic [W-1:0] w, output logic [W-1:0] x, output logic e);
    logic [3:0] d;
    x = '0;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = w[4*i +: 4];
`ifdef BCD_XS3_ERR_CHECK_EN
      if (int'(d) > 9) begin
        x[4*i +: 4] = 4'hF;
        e = 1'b1;
      end else begin
        x[4*i +: 4] = 4'((int'(d) + 3) % 16);
      end
`else
      x[4*i +: 4] = 4'((int'(d) + 3) % 16);
`endif
    end
  endfunction

  // Drives one word through, stalls the result for 'stall' cycles, then releases it.
  // lat counts clock edges from the accept edge to out_valid; -1 means the word never completed.
  task automatic run_word(input logic [W-1:0] w, input int stall,
                          output int lat, output logic [W-1:0] xs3, output logic err,
                          output bit flow_bad, output bit hold_bad,
                          output logic after_valid, output logic after_ready,
                          output logic [W-1:0] after_xs3);
    int n;
    lat = -1; xs3 = '0; err = 1'b0; flow_bad = 1'b0; hold_bad = 1'b0;
    after_valid = 1'b1; after_ready = 1'b0; after_xs3 = '0;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = w;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_bcd   = ~w;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      if (bus.in_ready || !bus.busy) flow_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) return;
    lat = n;
    xs3 = bus.out_xs3;
    err = bus.out_err;
    for (int s = 0; s < stall; s++) begin
      if (bus.in_ready || !bus.busy || !bus.out_valid || bus.out_xs3 !== xs3 || bus.out_err !== err)
        hold_bad = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_bcd   = $urandom();
      @(negedge clk);
    end
    if (bus.in_ready || !bus.out_valid || bus.out_xs3 !== xs3) hold_bad = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    after_valid = bus.out_valid;
    after_ready = bus.in_ready;
    after_xs3   = bus.out_xs3;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    vectors++;
    if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    vectors++;
    if (bus.out_xs3 !== '0) begin miscompares++; $display("FAIL reset_out_xs3: got %h want 0000", bus.out_xs3); end
    vectors++;
    if (bus.out_err !== 1'b0) begin miscompares++; $display("FAIL reset_out_err: got %b want 0", bus.out_err); end
    vectors++;
    if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    int lat; logic [W-1:0] x, ax; logic e, av, ar; bit fb, hb;
    run_word(16'h1234, 0, lat, x, e, fb, hb, av, ar, ax);
    vectors++;
    if (lat !== DIGITS) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", lat, DIGITS); end
    vectors++;
    if (x !== 16'h4567) begin miscompares++; $display("FAIL basic_xs3: got %h want 4567", x); end
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b want 0", e); end
    vectors++;
    if (av !== 1'b0 || ar !== 1'b1) begin miscompares++; $display("FAIL basic_pulse: valid %b ready %b want 0 1", av, ar); end
    vectors++;
    if (ax !== 16'h4567) begin miscompares++; $display("FAIL basic_idle_hold: got %h want 4567", ax); end
    vectors++;
    if (fb) begin miscompares++; $display("FAIL basic_flow: in_ready/busy wrong during CONV"); end
  endtask

  task automatic test_patterns();
    logic [W-1:0] words [2] = '{16'h0999, 16'h9000};
    logic [W-1:0] wants [2] = '{16'h3CCC, 16'hC333};
    int lat; logic [W-1:0] x, ax; logic e, av, ar; bit fb, hb;
    for (int i = 0; i < 2; i++) begin
      run_word(words[i], 2, lat, x, e, fb, hb, av, ar, ax);
      vectors++;
      if (x !== wants[i]) begin miscompares++; $display("FAIL pattern_xs3[%0d]: got %h want %h", i, x, wants[i]); end
      vectors++;
      if (fb || hb) begin miscompares++; $display("FAIL pattern_ready[%0d]: flow %b hold %b want 0 0", i, fb, hb); end
      vectors++;
      if (lat !== DIGITS) begin miscompares++; $display("FAIL pattern_latency[%0d]: got %0d want %0d", i, lat, DIGITS); end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [W-1:0] x, ax; logic e, av, ar; bit fb, hb;
    run_word(16'h5678, 10, lat, x, e, fb, hb, av, ar, ax);
    vectors++;
    if (x !== 16'h89AB) begin miscompares++; $display("FAIL bp_xs3: got %h want 89AB", x); end
    vectors++;
    if (hb) begin miscompares++; $display("FAIL bp_hold: outputs changed or in_ready rose during stall"); end
    vectors++;
    if (av !== 1'b0 || ar !== 1'b1) begin miscompares++; $display("FAIL bp_release: valid %b ready %b want 0 1", av, ar); end
  endtask

  task automatic test_invalid_digit();
    int lat; logic [W-1:0] x, ax, wx; logic e, av, ar, we; bit fb, hb;
`ifdef BCD_XS3_ERR_CHECK_EN
    wx = 16'h45F7; we = 1'b1;
`else
    wx = 16'h45D7; we = 1'b0;
`endif
    run_word(16'h12A4, 1, lat, x, e, fb, hb, av, ar, ax);
    vectors++;
    if (x !== wx) begin miscompares++; $display("FAIL invalid_xs3: got %h want %h", x, wx); end
    vectors++;
    if (e !== we) begin miscompares++; $display("FAIL invalid_err: got %b want %b", e, we); end
    run_word(16'h0000, 0, lat, x, e, fb, hb, av, ar, ax);
    vectors++;
    if (x !== 16'h3333) begin miscompares++; $display("FAIL after_invalid_xs3: got %h want 3333", x); end
    vectors++;
    if (e !== 1'b0) begin miscompares++; $display("FAIL after_invalid_err: got %b want 0", e); end
  endtask

  task automatic test_reset_abort();
    int n, lat; logic [W-1:0] x, ax; logic e, av, ar; bit fb, hb, rose;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = 16'h4321;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out_xs3 !== '0 || bus.out_err !== 1'b0 || bus.busy !== 1'b0)
      begin miscompares++; $display("FAIL abort_outputs: valid %b xs3 %h err %b busy %b want 0 0000 0 0", bus.out_valid, bus.out_xs3, bus.out_err, bus.busy); end
    vectors++;
    if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready_in_rst: got %b want 0", bus.in_ready); end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready_after: got %b want 1", bus.in_ready); end
    rose = 1'b0;
    for (int i = 0; i < DIGITS + 3; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) rose = 1'b1;
    end
    vectors++;
    if (rose) begin miscompares++; $display("FAIL abort_no_valid: out_valid rose 1 want 0"); end
    bus.out_ready = 1'b0;
    run_word(16'h8765, 0, lat, x, e, fb, hb, av, ar, ax);
    vectors++;
    if (x !== 16'hBA98) begin miscompares++; $display("FAIL abort_next_xs3: got %h want BA98", x); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w1, w2, x1, x2, r1, r2;
    logic e1, e2;
    int n, gap;
    w1 = 16'h2468; w2 = 16'h1357;
    ref_xs3(w1, x1, e1);
    ref_xs3(w2, x2, e2);
    r1 = '0; r2 = '0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = w1;
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.in_bcd = w2;
    gap = 0;
    while (!bus.in_ready && gap < 50) begin
      if (bus.out_valid) r1 = bus.out_xs3;
      @(negedge clk);
      gap++;
    end
    vectors++;
    if (gap + 1 !== DIGITS + 2) begin miscompares++; $display("FAIL b2b_interval: got %0d want %0d", gap + 1, DIGITS + 2); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    r2 = bus.out_xs3;
    @(negedge clk);
    bus.out_ready = 1'b0;
    vectors++;
    if (r1 !== x1) begin miscompares++; $display("FAIL b2b_first: got %h want %h", r1, x1); end
    vectors++;
    if (r2 !== x2) begin miscompares++; $display("FAIL b2b_second: got %h want %h", r2, x2); end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] w, x, ax, wx; logic e, av, ar, we; bit fb, hb;
    for (int i = 0; i < 24; i++) begin
      w = W'($urandom());
      ref_xs3(w, wx, we);
      run_word(w, int'($urandom_range(0, 3)), lat, x, e, fb, hb, av, ar, ax);
      vectors++;
      if (x !== wx || e !== we || lat !== DIGITS)
        begin miscompares++; $display("FAIL random[%0d] in %h: xs3 %h err %b lat %0d want %h %b %0d", i, w, x, e, lat, wx, we, DIGITS); end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bcd = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_patterns();
    test_backpressure();
    test_invalid_digit();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", vectors);
    $fatal(1);
  end

endmodule
